// File: rtl/ddram_share_pkg.sv
// Shared definitions for the DDRAM port sharer: command FSM encoding and the
// layout of one buffered write, packed as {addr, data, byte enables}.
package ddram_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    // Width of one write-FIFO entry for a given DDRAM word-address width.
    function automatic int entry_w(input int aw);
        return aw + DATA_W + BE_W;
    endfunction

endpackage

// File: rtl/ddram_share_fifo.sv
// Show-ahead write FIFO. Besides the head it exposes the entry behind it so the
// command sequencer can issue back-to-back writes on the cycle it pops.
module ddram_share_fifo
    import ddram_share_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 101
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [W-1:0]           second,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_LVL  = (PW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_nxt;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_nxt  = rd_ptr + 1'b1;
    assign head    = mem[rd_ptr];
    // With a single stored entry, the next one is whatever is being pushed now.
    assign second  = (level == ONE_LVL) ? din : mem[rd_nxt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddram_share.sv
// Shares one DDRAM Avalon-style port between a buffered single-beat writer and
// a burst reader, with one read outstanding and a count of dropped writes.
module ddram_share
    import ddram_share_pkg::*;
#(
    parameter int AW    = 29,
    parameter int DEPTH = 16,
    parameter int HI_WM = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_din,
    input  logic [7:0]    wr_be,
    output logic          wr_full,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_burst,
    output logic          rd_ack,
    output logic [63:0]   rd_dout,
    output logic          rd_dvalid,
    output logic          rd_done,
    output logic [15:0]   ovf_cnt,
    input  logic          DDRAM_BUSY,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [AW-1:0] DDRAM_ADDR,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_WE,
    output logic          DDRAM_RD
);

    localparam int          EW     = entry_w(AW);
    localparam int          LW     = $clog2(DEPTH);
    localparam logic [LW:0] HI_LVL = (LW+1)'(HI_WM);

    state_t        state;
    state_t        state_d;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic [EW-1:0] second;
    logic [EW-1:0] wr_entry;
    logic [LW:0]   level;
    logic [LW:0]   lvl_after;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop;
    logic          cmd_done;
    logic          load_wr;
    logic          load_rd;
    logic [7:0]    cnt;
    logic [7:0]    cnt_d;
    logic          we_d;
    logic          rd_d;
    logic          ack_d;
    logic          dvalid_d;
    logic          done_d;
    logic [AW-1:0] addr_d;
    logic [63:0]   din_d;
    logic [63:0]   dout_d;
    logic [7:0]    be_d;
    logic [7:0]    bc_d;

    assign push_entry = {wr_addr, wr_din, wr_be};
    assign push_ok    = wr_req & ~full;
    assign cmd_done   = (DDRAM_WE | DDRAM_RD) & ~DDRAM_BUSY;
    assign pop        = DDRAM_WE & ~DDRAM_BUSY;
    assign wr_full    = full;

    ddram_share_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (wr_req),
        .din    (push_entry),
        .pop    (pop),
        .head   (head),
        .second (second),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        lvl_after = level;
        if (push_ok) lvl_after = lvl_after + 1'b1;
        if (pop)     lvl_after = lvl_after - 1'b1;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (level >= HI_LVL)  state_d = WR;
                else if (rd_req)      state_d = RD_CMD;
                else if (!empty)      state_d = WR;
            end
            WR: begin
                if (cmd_done) begin
                    if (rd_req && (lvl_after < HI_LVL)) state_d = RD_CMD;
                    else if (lvl_after != '0)           state_d = WR;
                    else                                state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (cmd_done) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (DDRAM_DOUT_READY && (cnt == 8'd1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered DDRAM and client outputs.
    always_comb begin
        load_wr  = (state_d == WR) && ((state == IDLE) || ((state == WR) && cmd_done));
        load_rd  = (state_d == RD_CMD) && (state != RD_CMD);
        wr_entry = (state == IDLE) ? head : second;
        we_d     = (state_d == WR);
        rd_d     = (state_d == RD_CMD);
        addr_d   = DDRAM_ADDR;
        din_d    = DDRAM_DIN;
        be_d     = DDRAM_BE;
        bc_d     = DDRAM_BURSTCNT;
        if (load_wr) begin
            addr_d = wr_entry[EW-1 -: AW];
            din_d  = wr_entry[BE_W +: DATA_W];
            be_d   = wr_entry[BE_W-1:0];
            bc_d   = 8'd1;
        end else if (load_rd) begin
            addr_d = rd_addr;
            bc_d   = (rd_burst == 8'd0) ? 8'd1 : rd_burst;
        end
        ack_d    = (state == RD_CMD) && cmd_done;
        dvalid_d = (state == RD_DATA) && DDRAM_DOUT_READY;
        done_d   = dvalid_d && (cnt == 8'd1);
        dout_d   = dvalid_d ? DDRAM_DOUT : rd_dout;
        cnt_d    = cnt;
        if (ack_d)         cnt_d = DDRAM_BURSTCNT;
        else if (dvalid_d) cnt_d = cnt - 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            DDRAM_WE       <= 1'b0;
            DDRAM_RD       <= 1'b0;
            DDRAM_BURSTCNT <= 8'd1;
            DDRAM_ADDR     <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
            rd_ack         <= 1'b0;
            rd_dvalid      <= 1'b0;
            rd_done        <= 1'b0;
            rd_dout        <= '0;
            cnt            <= '0;
        end else begin
            state          <= state_d;
            DDRAM_WE       <= we_d;
            DDRAM_RD       <= rd_d;
            DDRAM_BURSTCNT <= bc_d;
            DDRAM_ADDR     <= addr_d;
            DDRAM_DIN      <= din_d;
            DDRAM_BE       <= be_d;
            rd_ack         <= ack_d;
            rd_dvalid      <= dvalid_d;
            rd_done        <= done_d;
            rd_dout        <= dout_d;
            cnt            <= cnt_d;
        end
    end

    // A write arriving while the registered level reads full is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (wr_req && full && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule
